// File: rtl/vrf_pair_sequencer_if.sv
// vrf_pair_sequencer_if: bundles the command, VRF, operand and result signals
// of the VRF pair sequencer. The "master" modport is the sequencer side and
// the "slave" modport is the surrounding system (requester, VRF, compute unit).
//
// Handshake semantics, for every valid/ready pair here (cmd, op, res):
//   a transfer happens on a rising clk edge where valid and ready are both 1;
//   once valid is raised the sender holds it and its payload stable until that
//   transfer; ready may rise and fall freely and never waits on valid.
interface vrf_pair_sequencer_if #(
   parameter int DW = 64,
   parameter int AW = 5
);
   // command channel
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_src;
   logic [AW-1:0] cmd_dst;
   logic [AW:0]   cmd_len;
   logic          done;

   // VRF read port (dual-word read, registered in the VRF)
   logic [1:0]    vrf_r_am;
   logic [AW-1:0] vrf_r_addr;
   logic [DW-1:0] vrf_rd_a;
   logic [DW-1:0] vrf_rd_b;

   // VRF write port
   logic [1:0]    vrf_w_am;
   logic [AW-1:0] vrf_w_addr;
   logic [DW-1:0] vrf_wdata;

   // operand stream to the compute unit
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;

   // result stream from the compute unit
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;

   modport master (
      input  cmd_valid, cmd_src, cmd_dst, cmd_len,
      output cmd_ready, done,
      output vrf_r_am, vrf_r_addr,
      input  vrf_rd_a, vrf_rd_b,
      output vrf_w_am, vrf_w_addr, vrf_wdata,
      output op_valid, op_a, op_b,
      input  op_ready,
      input  res_valid, res_data,
      output res_ready
   );

   modport slave (
      output cmd_valid, cmd_src, cmd_dst, cmd_len,
      input  cmd_ready, done,
      input  vrf_r_am, vrf_r_addr,
      output vrf_rd_a, vrf_rd_b,
      input  vrf_w_am, vrf_w_addr, vrf_wdata,
      input  op_valid, op_a, op_b,
      output op_ready,
      output res_valid, res_data,
      input  res_ready
   );
endinterface

// File: rtl/vrf_pair_sequencer.sv
// vrf_pair_sequencer: compute-side master for the 32x64 VRF. For one command
// it reads len operand pairs starting at src (stride 2, 5-bit wrap), streams
// them to the compute unit through a small FIFO, and writes len results back
// starting at dst (stride 1, 5-bit wrap).
// Optional feature: define VRF_SEQ_PERF_EN to add perf_busy/perf_stall
// saturating cycle counters.
// dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 WAIT, 3 DONE).
module vrf_pair_sequencer #(
   parameter int DW     = 64,
   parameter int AW     = 5,
   parameter int FDEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   vrf_pair_sequencer_if.master bus,
`ifdef VRF_SEQ_PERF_EN
   output logic [15:0]          perf_busy,
   output logic [15:0]          perf_stall,
`endif
   output logic [1:0]           dbg_state
);

   localparam int          PW       = $clog2(FDEPTH);
   localparam int          CW       = PW + 1;
   localparam logic [CW:0] FDEPTH_W = (CW+1)'(FDEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // command progress
   logic [AW:0]   len_q;
   logic [AW:0]   rd_cnt_q;
   logic [AW:0]   wr_cnt_q;
   logic [AW-1:0] rd_addr_q;
   logic [AW-1:0] wr_addr_q;
   logic          rd_pend_q;

   // operand FIFO, each entry is {op_a, op_b}
   logic [2*DW-1:0] fifo_mem [FDEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   fcount_q;

   // registered VRF write strobe
   logic [1:0]    w_am_q;
   logic [AW-1:0] w_addr_q;
   logic [DW-1:0] wdata_q;

   logic cmd_fire;
   logic rd_issue;
   logic fifo_push;
   logic fifo_pop;
   logic fifo_ne;
   logic res_open;
   logic res_fire;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state plus the per-cycle strobes that depend on it
   always_comb begin
      state_d   = state_q;
      cmd_fire  = 1'b0;
      rd_issue  = 1'b0;
      res_open  = 1'b0;
      fifo_ne   = (fcount_q != '0);
      fifo_pop  = fifo_ne && bus.op_ready;
      fifo_push = rd_pend_q;
      case (state_q)
         S_IDLE: begin
            cmd_fire = bus.cmd_valid;
            if (bus.cmd_valid) state_d = (bus.cmd_len == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            // one read in flight at most, and never more than the FIFO can absorb
            rd_issue = (rd_cnt_q < len_q) &&
                       (({1'b0, fcount_q} + {{CW{1'b0}}, rd_pend_q}) < FDEPTH_W);
            res_open = (wr_cnt_q < len_q);
            if (rd_cnt_q == len_q) state_d = S_WAIT;
         end
         S_WAIT: begin
            res_open = (wr_cnt_q < len_q);
            // the final write strobe is on the VRF port in this cycle
            if (wr_cnt_q == len_q) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // reset kills any read strobe in the very cycle it is asserted
      if (rst) rd_issue = 1'b0;
      res_fire = res_open && bus.res_valid;
   end

   // command latch, read/write counters and the registered write strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         rd_pend_q <= 1'b0;
         w_am_q    <= 2'b00;
         w_addr_q  <= '0;
         wdata_q   <= '0;
      end else begin
         if (cmd_fire) begin
            len_q     <= bus.cmd_len;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_addr_q <= bus.cmd_src;
            wr_addr_q <= bus.cmd_dst;
         end
         if (rd_issue) begin
            rd_addr_q <= rd_addr_q + AW'(2);
            rd_cnt_q  <= rd_cnt_q + (AW+1)'(1);
         end
         rd_pend_q <= rd_issue;
         w_am_q    <= res_fire ? 2'b01 : 2'b00;
         if (res_fire) begin
            w_addr_q  <= wr_addr_q;
            wdata_q   <= bus.res_data;
            wr_addr_q <= wr_addr_q + AW'(1);
            wr_cnt_q  <= wr_cnt_q + (AW+1)'(1);
         end
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide at any fill level
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcount_q <= '0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         fcount_q <= fcount_q + {{(CW-1){1'b0}}, fifo_push} - {{(CW-1){1'b0}}, fifo_pop};
      end
   end

   // FIFO storage: capture the VRF pair the cycle after the read strobe
   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr_q] <= {bus.vrf_rd_a, bus.vrf_rd_b};
   end

   assign bus.cmd_ready  = (state_q == S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.vrf_r_am   = {1'b0, rd_issue};
   assign bus.vrf_r_addr = rd_addr_q;
   assign bus.vrf_w_am   = w_am_q;
   assign bus.vrf_w_addr = w_addr_q;
   assign bus.vrf_wdata  = wdata_q;
   assign bus.op_valid   = fifo_ne;
   // an empty FIFO presents zeros rather than stale entries
   assign bus.op_a       = fifo_ne ? fifo_mem[rd_ptr_q][2*DW-1:DW] : '0;
   assign bus.op_b       = fifo_ne ? fifo_mem[rd_ptr_q][DW-1:0]    : '0;
   assign bus.res_ready  = res_open;
   assign dbg_state      = state_q;

`ifdef VRF_SEQ_PERF_EN
   // saturating busy/stall counters, cleared by reset and by each new command
   always_ff @(posedge clk) begin
      if (rst || cmd_fire) begin
         perf_busy  <= '0;
         perf_stall <= '0;
      end else begin
         if ((state_q != S_IDLE) && (perf_busy != 16'hFFFF))
            perf_busy <= perf_busy + 16'd1;
         if (fifo_ne && !bus.op_ready && (perf_stall != 16'hFFFF))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vrf_pair_sequencer.sv
// tb_vrf_pair_sequencer: directed bench for vrf_pair_sequencer with a
// behavioural VRF, a summing compute unit and expected-value queues.
module tb_vrf_pair_sequencer;
   localparam int DW     = 64;
   localparam int AW     = 5;
   localparam int FDEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;
`ifdef VRF_SEQ_PERF_EN
   logic [15:0] perf_busy;
   logic [15:0] perf_stall;
`endif

   vrf_pair_sequencer_if #(.DW(DW), .AW(AW)) bus ();

   vrf_pair_sequencer #(.DW(DW), .AW(AW), .FDEPTH(FDEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
`ifdef VRF_SEQ_PERF_EN
      .perf_busy (perf_busy),
      .perf_stall(perf_stall),
`endif
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int checks     = 0;
   int failures   = 0;
   int rd_strobes = 0;
   int wr_strobes = 0;
   int done_cnt   = 0;
   int pop_cnt    = 0;
   int done_base  = 0;
   logic res_fire = 1'b0;
   bit   res_gaps = 1'b0;

   logic [DW-1:0]    vmem [32];
   logic [2*DW-1:0]  exp_op_q[$];
   logic [AW+DW-1:0] exp_wr_q[$];
   logic [AW+DW-1:0] cmd_wr_list[$];
   logic [DW-1:0]    res_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- VRF model: registered dual read, write on strobe ----------------
   always @(posedge clk) begin
      if (bus.vrf_r_am == 2'b01) begin
         bus.vrf_rd_a <= vmem[bus.vrf_r_addr];
         bus.vrf_rd_b <= vmem[bus.vrf_r_addr + 5'd1];
      end
      if (bus.vrf_w_am == 2'b01) vmem[bus.vrf_w_addr] <= bus.vrf_wdata;
   end

   // ---------------- monitor: sampled on the falling edge ----------------
   initial begin
      logic [2*DW-1:0]  eo;
      logic [AW+DW-1:0] ew;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (bus.vrf_r_am == 2'b01) rd_strobes++;
            if (bus.done) done_cnt++;
            if (bus.vrf_w_am == 2'b01) begin
               wr_strobes++;
               if (exp_wr_q.size() == 0) chk("wr_unexpected", exp_wr_q.size(), 1);
               else begin
                  ew = exp_wr_q.pop_front();
                  chk("vrf_write", {bus.vrf_w_addr, bus.vrf_wdata}, ew);
               end
            end
            if (bus.op_valid && bus.op_ready) begin
               pop_cnt++;
               res_q.push_back(bus.op_a + bus.op_b);
               if (exp_op_q.size() == 0) chk("op_unexpected", exp_op_q.size(), 1);
               else begin
                  eo = exp_op_q.pop_front();
                  chk("op_pair", {bus.op_a, bus.op_b}, eo);
               end
            end
            if (bus.res_valid && bus.res_ready) res_fire = 1'b1;
         end
      end
   end

   // ---------------- compute unit: returns op_a+op_b, optional gaps ----------------
   initial begin
      bus.res_valid = 1'b0;
      bus.res_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            res_q.delete();
            bus.res_valid = 1'b0;
            res_fire      = 1'b0;
         end else begin
            if (res_fire) begin
               void'(res_q.pop_front());
               bus.res_valid = 1'b0;
               res_fire      = 1'b0;
            end
            if (!bus.res_valid && res_q.size() > 0 &&
                (!res_gaps || $urandom_range(0, 2) == 0)) begin
               bus.res_valid = 1'b1;
               bus.res_data  = res_q[0];
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len);
      logic [AW-1:0] ra, rb, wa;
      logic [DW-1:0] sum;
      int n;
      cmd_wr_list.delete();
      for (int i = 0; i < len; i++) begin
         ra  = src + AW'(2 * i);
         rb  = ra + AW'(1);
         wa  = dst + AW'(i);
         sum = vmem[ra] + vmem[rb];
         exp_op_q.push_back({vmem[ra], vmem[rb]});
         exp_wr_q.push_back({wa, sum});
         cmd_wr_list.push_back({wa, sum});
      end
      n = 0;
      while (!bus.cmd_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      done_base     = done_cnt;
      bus.cmd_valid = 1'b1;
      bus.cmd_src   = src;
      bus.cmd_dst   = dst;
      bus.cmd_len   = (AW+1)'(len);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd(input string tag);
      int n;
      n = 0;
      while (done_cnt == done_base && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done_seen"}, (done_cnt != done_base), 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk({tag, "_done_once"}, done_cnt - done_base, 1);
      chk({tag, "_idle"}, dbg_state, 0);
      chk({tag, "_ops_left"}, exp_op_q.size(), 0);
      chk({tag, "_wr_left"}, exp_wr_q.size(), 0);
      foreach (cmd_wr_list[k])
         chk({tag, "_mem"}, vmem[cmd_wr_list[k][AW+DW-1:DW]], cmd_wr_list[k][DW-1:0]);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int rd_base, wr_base, pop_base, n;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_src   = '0;
      bus.cmd_dst   = '0;
      bus.cmd_len   = '0;
      bus.op_ready  = 1'b0;
      for (int i = 0; i < 32; i++) vmem[i] <= {$urandom, $urandom};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_r_am", bus.vrf_r_am, 0);
      chk("rst_w_am", bus.vrf_w_am, 0);
      chk("rst_op_valid", bus.op_valid, 0);
      chk("rst_op_a", bus.op_a, 0);
      chk("rst_res_ready", bus.res_ready, 0);
      chk("rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: four pairs from 0 into 16..19, everything always ready
      bus.op_ready = 1'b1;
      @(posedge clk); #1;
      start_cmd(5'd0, 5'd16, 4);
      finish_cmd("t1");

      // 2: read wrap 30/31 -> 0/1, write wrap 31 -> 0
      start_cmd(5'd30, 5'd31, 2);
      finish_cmd("t2");

      // 3: compute unit stalled: reads stop once the FIFO is committed
      bus.op_ready = 1'b0;
      rd_base = rd_strobes;
      start_cmd(5'd2, 5'd20, 8);
      repeat (20) begin
         @(posedge clk); #1;
      end
      chk("t3_reads_stalled", rd_strobes - rd_base, FDEPTH);
      chk("t3_op_valid", bus.op_valid, 1);
      bus.op_ready = 1'b1;
      @(negedge clk);
      chk("t3_no_read_before_pop", bus.vrf_r_am, 0);
      finish_cmd("t3");
      chk("t3_reads_total", rd_strobes - rd_base, 8);

      // 4: zero-length command
      rd_base = rd_strobes;
      wr_base = wr_strobes;
      start_cmd(5'd5, 5'd9, 0);
      chk("t4_done_next_cycle", bus.done, 1);
      finish_cmd("t4");
      chk("t4_no_reads", rd_strobes - rd_base, 0);
      chk("t4_no_writes", wr_strobes - wr_base, 0);

      // 5: reset in the middle of a command, then a fresh command
      pop_base = pop_cnt;
      start_cmd(5'd8, 5'd0, 8);
      n = 0;
      while ((pop_cnt - pop_base) < 3 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_three_pops", ((pop_cnt - pop_base) >= 3), 1);
      bus.op_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t5_cmd_ready", bus.cmd_ready, 1);
      chk("t5_op_valid", bus.op_valid, 0);
      chk("t5_r_am", bus.vrf_r_am, 0);
      chk("t5_w_am", bus.vrf_w_am, 0);
      chk("t5_state", dbg_state, 0);
      exp_op_q.delete();
      exp_wr_q.delete();
      cmd_wr_list.delete();
      @(negedge clk);
      rst = 1'b0;
      rd_base = rd_strobes;
      wr_base = wr_strobes;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("t5_quiet_reads", rd_strobes - rd_base, 0);
      chk("t5_quiet_writes", wr_strobes - wr_base, 0);
      bus.op_ready = 1'b1;
      start_cmd(5'd4, 5'd28, 2);
      finish_cmd("t5b");

      // 6: stray command during RUN is ignored; result gaps randomised
      res_gaps = 1'b1;
      start_cmd(5'd10, 5'd26, 8);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("t6_cmd_ready_busy", bus.cmd_ready, 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_src   = 5'd0;
      bus.cmd_dst   = 5'd0;
      bus.cmd_len   = 6'd1;
      @(posedge clk); #1;
      chk("t6_still_busy", (dbg_state != 2'd0), 1);
      bus.cmd_valid = 1'b0;
      finish_cmd("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
